// File: rtl/qu_dmem.sv
// qu_dmem: word-organised data memory with a request FSM (IDLE/WR_ACK/RD_WAIT/RESP).
// Writes answer after one cycle and reads after RD_LATENCY cycles. While a request
// is in flight the block is busy, and any new request is dropped.
// Optional feature: define QU_DMEM_ALIGN_CHECK_EN to reject malformed byte-enable
// patterns and misaligned reads. A rejected access writes nothing, still responds at
// normal latency, and raises dmem_err_out.
module qu_dmem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dmem_wr_en_in,
    input  logic        dmem_rd_en_in,
    input  logic [31:0] dmem_addr_in,
    input  logic [31:0] dmem_data_in,
    output logic        dmem_valid_out,
    output logic [31:0] dmem_data_out,
    output logic        dmem_busy_out,
    output logic        dmem_err_out
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACK  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] req_idx;
    logic          wr_req;
    logic          rd_req;
    logic          wr_bad;
    logic          rd_bad;
    logic          resp_err;
    logic          mem_we;

    // Upper address bits are ignored so the array aliases modulo its size. The byte
    // offset only matters when alignment checking is built in.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr_in[31:AW+2], dmem_addr_in[1:0]};

    assign req_idx = dmem_addr_in[AW+1:2];
    assign wr_req  = (dmem_wr_en_in != 4'b0000);
    assign rd_req  = dmem_rd_en_in;

`ifdef QU_DMEM_ALIGN_CHECK_EN
    logic err_q, err_d;

    // Legal enable patterns are a single byte, an aligned halfword, or the full word.
    assign wr_bad   = !(dmem_wr_en_in inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                              4'b0011, 4'b1100, 4'b1111});
    assign rd_bad   = (dmem_addr_in[1:0] != 2'b00);
    assign resp_err = err_q;
`else
    assign wr_bad   = 1'b0;
    assign rd_bad   = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Memory is written only when a write is accepted in IDLE. Reset cycles are
    // excluded so that a reset never disturbs the contents.
    assign mem_we = rst && (state_q == IDLE) && wr_req && !wr_bad;

    // Next state. A write takes priority over a simultaneous read, and the read is
    // dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef QU_DMEM_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WR_ACK;
`ifdef QU_DMEM_ALIGN_CHECK_EN
                    err_d   = wr_bad;
`endif
                end else if (rd_req) begin
                    idx_d   = req_idx;
                    cnt_d   = LAT_LOAD;
                    state_d = (RD_LATENCY == 1) ? RESP : RD_WAIT;
`ifdef QU_DMEM_ALIGN_CHECK_EN
                    err_d   = rd_bad;
`endif
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            RD_WAIT: begin
                // RD_WAIT lasts RD_LATENCY-1 cycles, so RESP lands RD_LATENCY
                // cycles after acceptance.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers. Reset aborts any in-flight request without a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef QU_DMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef QU_DMEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Byte-lane memory writes. There is no reset, so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wr_en_in[b]) begin
                    mem_q[req_idx][8*b +: 8] <= dmem_data_in[8*b +: 8];
                end
            end
        end
    end

    // Outputs decode from the state. IDLE (which covers reset) drives everything
    // to 0. Read data is sampled live in RESP.
    always_comb begin
        dmem_valid_out = (state_q == WR_ACK) || (state_q == RESP);
        dmem_busy_out  = (state_q != IDLE);
        dmem_err_out   = dmem_valid_out && resp_err;
        dmem_data_out  = 32'h0;
        if ((state_q == RESP) && !resp_err) begin
            dmem_data_out = mem_q[idx_q];
        end
    end

endmodule

// File: tb/tb_qu_dmem.sv
// tb_qu_dmem: directed scenarios followed by random traffic. All traffic is checked
// against a word-array model of the memory and its response timing.
module tb_qu_dmem;

    localparam int DEPTH = 16;
    localparam int RDL   = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mdl [DEPTH];

    qu_dmem #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(RDL)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_wr_en_in  (wr_en),
        .dmem_rd_en_in  (rd_en),
        .dmem_addr_in   (addr),
        .dmem_data_in   (wdata),
        .dmem_valid_out (valid),
        .dmem_data_out  (rdata),
        .dmem_busy_out  (busy),
        .dmem_err_out   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic b,
                           input logic e, input logic [31:0] d);
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
        chk({tag, ".busy"},  {31'h0, busy},  {31'h0, b});
        chk({tag, ".err"},   {31'h0, err},   {31'h0, e});
        chk({tag, ".data"},  rdata, d);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic exp_err(input logic is_wr, input logic [3:0] en,
                                     input logic [31:0] a);
`ifdef QU_DMEM_ALIGN_CHECK_EN
        if (is_wr) return !(en == 4'h1 || en == 4'h2 || en == 4'h4 || en == 4'h8 ||
                             en == 4'h3 || en == 4'hC || en == 4'hF);
        return (a[1:0] != 2'b00);
`else
        return 1'b0 & is_wr & en[0] & a[0];
`endif
    endfunction

    // Present one request in the current (idle) cycle and check every cycle up to
    // and including the return to idle. rd_out holds the data seen at the response.
    task automatic access(input string tag, input logic rd, input logic [3:0] en,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd_out);
        logic        is_wr;
        logic        is_rd;
        logic        e;
        int          lat;
        logic [31:0] exp_d;
        is_wr  = (en != 4'h0);
        is_rd  = rd && !is_wr;
        rd_out = 32'h0;
        rd_en = rd; wr_en = en; addr = a; wdata = d;
        if (!is_wr && !is_rd) begin
            @(negedge clk);
            chk_out({tag, ".nop"}, 1'b0, 1'b0, 1'b0, 32'h0);
            return;
        end
        e     = exp_err(is_wr, en, a);
        lat   = is_wr ? 1 : RDL;
        exp_d = (is_rd && !e) ? mdl[widx(a)] : 32'h0;
        if (is_wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (en[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin rd_en = 1'b0; wr_en = 4'h0; end
            if (k == lat) begin
                rd_out = rdata;
                chk_out({tag, ".resp"}, 1'b1, 1'b1, e, exp_d);
            end else begin
                chk_out({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 32'h0);
            end
        end
        @(negedge clk);
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] prior;
        rst = 1'b0; rd_en = 1'b0; wr_en = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Fill every word so that the model is fully defined
        for (int i = 0; i < DEPTH; i++)
            access("init", 1'b0, 4'hF, 32'(i * 4), $urandom, r);

        // Write then read
        access("w_dead", 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, r);
        access("r_dead", 1'b1, 4'h0, 32'h10, 32'h0, r);
        chk("r_dead.const", r, 32'hDEADBEEF);

        // Byte write
        access("w_byte", 1'b0, 4'h1, 32'h10, 32'h000000AA, r);
        access("r_byte", 1'b1, 4'h0, 32'h10, 32'h0, r);
        chk("r_byte.const", r, 32'hDEADBEAA);

        // Request while busy: a write presented during RD_WAIT is dropped
        prior = mdl[widx(32'h20)];
        rd_en = 1'b1; addr = 32'h10;
        @(negedge clk);
        rd_en = 1'b0;
        chk_out("busy.rdwait", 1'b0, 1'b1, 1'b0, 32'h0);
        wr_en = 4'hF; addr = 32'h20; wdata = 32'h5;
        @(negedge clk);
        wr_en = 4'h0;
        chk_out("busy.resp", 1'b1, 1'b1, 1'b0, 32'hDEADBEAA);
        @(negedge clk);
        chk_out("busy.idle", 1'b0, 1'b0, 1'b0, 32'h0);
        access("busy.rd20", 1'b1, 4'h0, 32'h20, 32'h0, r);
        chk("busy.prior", r, prior);

        // Simultaneous read and write: one write-timed response
        access("rw", 1'b1, 4'hF, 32'h30, 32'h12345678, r);
        @(negedge clk);
        chk_out("rw.nosecond", 1'b0, 1'b0, 1'b0, 32'h0);
        access("rw.rd", 1'b1, 4'h0, 32'h30, 32'h0, r);
        chk("rw.const", r, 32'h12345678);

        // Reset in the cycle after read acceptance
        rd_en = 1'b1; addr = 32'h30;
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_out("rstmid.a", 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_out("rstmid.b", 1'b0, 1'b0, 1'b0, 32'h0);
        access("rstmid.rd", 1'b1, 4'h0, 32'h30, 32'h0, r);
        chk("rstmid.intact", r, 32'h12345678);

        // Address wrap and enable pattern 0101
        access("wrap.w", 1'b0, 4'hF, 32'(DEPTH * 4 + 16), 32'hCAFEF00D, r);
        access("wrap.r", 1'b1, 4'h0, 32'h10, 32'h0, r);
        chk("wrap.const", r, 32'hCAFEF00D);
        access("en0101", 1'b0, 4'h5, 32'(DEPTH * 4 + 16), 32'h11223344, r);
        access("en0101.r", 1'b1, 4'h0, 32'h10, 32'h0, r);
`ifdef QU_DMEM_ALIGN_CHECK_EN
        chk("en0101.const", r, 32'hCAFEF00D);
`else
        chk("en0101.const", r, 32'hCA22F044);
`endif
        access("misalign", 1'b1, 4'h0, 32'h13, 32'h0, r);

        // Random traffic across the full address space
        for (int i = 0; i < 300; i++) begin
            int          op;
            logic [3:0]  en;
            logic        rd;
            op = int'($urandom_range(0, 9));
            rd = (op >= 1 && op <= 4) || (op == 9);
            en = (op >= 5) ? 4'($urandom_range(1, 15)) : 4'h0;
            access("rand", rd, en, $urandom, $urandom, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/qu_dmem.md
QU_DMEM -- requirements
Module: qu_dmem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (a power of two, at least 4).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning the cycles from read acceptance to the read response (at least 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port dmem_wr_en_in, input, 4 bits: per-byte write enables from the retire stage.
REQ-006 SHALL have port dmem_rd_en_in, input, 1 bit: read request.
REQ-007 SHALL have port dmem_addr_in, input, 32 bits: byte address.
REQ-008 SHALL have port dmem_data_in, input, 32 bits: write data, byte lanes aligned to the enables.
REQ-009 SHALL have port dmem_valid_out, output, 1 bit: one-cycle response strobe for both reads and writes.
REQ-010 SHALL have port dmem_data_out, output, 32 bits: read data, valid only while dmem_valid_out is high.
REQ-011 SHALL have port dmem_busy_out, output, 1 bit: a request is in flight, so new requests are ignored.
REQ-012 SHALL have port dmem_err_out, output, 1 bit: access error, qualified by dmem_valid_out.

Function
REQ-013 SHALL implement the FSM states IDLE, WR_ACK, RD_WAIT and RESP.
REQ-014 SHALL accept a request only in IDLE, when dmem_rd_en_in=1 or dmem_wr_en_in!=0.
REQ-015 SHALL ignore requests arriving in any other state, with no memory update and no response.
REQ-016 SHALL hold dmem_busy_out=1 in every state except IDLE.
REQ-017 SHALL form the word index from dmem_addr_in[log2(DEPTH_WORDS)+1:2] and ignore the upper address bits, so addresses wrap modulo the memory size.
REQ-018 SHALL treat a write as follows:
- enabled bytes are written at the rising edge of the acceptance cycle; disabled bytes are unchanged;
- the state moves IDLE->WR_ACK;
- in WR_ACK, dmem_valid_out=1 for one cycle (latency 1), then the state returns to IDLE.
REQ-019 SHALL treat a read as follows:
- the word index is latched at acceptance;
- a latency counter loads RD_LATENCY-1;
- RD_WAIT decrements the counter to 0, then moves to RESP;
- when RD_LATENCY=1, the state moves IDLE->RESP directly.
REQ-020 SHALL in RESP assert dmem_valid_out=1 for one cycle, with dmem_data_out equal to the word contents as of the response cycle, then return to IDLE.
REQ-021 SHALL give the write priority when read and write are requested together, drop the read and respond as a write.
REQ-022 SHALL hold dmem_data_out at 0 whenever dmem_valid_out=0.
REQ-023 SHALL never assert dmem_valid_out in IDLE.
REQ-024 SHALL allow back-to-back requests, with a new request accepted in the cycle the FSM is back in IDLE; throughput is one request per (latency+1) cycles.

Reset
REQ-025 SHALL, while rst=0 at a rising edge, force the state to IDLE, the latency counter to 0, and dmem_valid_out, dmem_busy_out, dmem_err_out and dmem_data_out to 0.
REQ-026 SHALL, when reset arrives mid-operation, abort the in-flight request without a response.
REQ-027 SHALL never clear memory contents on reset.

Configuration
REQ-028 SHALL, with QU_DMEM_ALIGN_CHECK_EN defined, flag an access as an error when:
- a write has dmem_wr_en_in outside the set {0001, 0010, 0100, 1000, 0011, 1100, 1111}, or
- a read has dmem_addr_in[1:0]!=0.
REQ-029 SHALL, for an erroring access, write no memory and return the response at normal latency with dmem_err_out=1 and dmem_data_out=0.
REQ-030 SHALL, without QU_DMEM_ALIGN_CHECK_EN, honour every enable pattern as given, ignore dmem_addr_in[1:0] and tie dmem_err_out to 0.

Verification
REQ-031 SHALL cover a write then a read:
- stimulus: write 0xDEADBEEF to 0x10 with enables 1111, then read 0x10 with RD_LATENCY=2;
- response: valid 1 cycle after the write, then valid 2 cycles after read acceptance with data 0xDEADBEEF.
REQ-032 SHALL cover a byte write:
- stimulus: after the scenario in REQ-031, write 0x000000AA with enables 0001 to 0x10, then read 0x10;
- response: data 0xDEADBEAA.
REQ-033 SHALL cover a request while busy:
- stimulus: a read is in RD_WAIT and a write of 0x5 to 0x20 is presented;
- response: busy=1, the write is ignored, and a later read of 0x20 returns the prior contents.
REQ-034 SHALL cover simultaneous read and write:
- stimulus: read and write with enables 1111 and data 0x12345678 in the same cycle at 0x30;
- response: a single valid after 1 cycle, and a subsequent read returns 0x12345678.
REQ-035 SHALL cover reset mid-read:
- stimulus: rst=0 in the cycle after read acceptance;
- response: no valid pulse, state IDLE, busy=0, and memory intact.
REQ-036 SHALL cover address wrap and the alignment check:
- with QU_DMEM_ALIGN_CHECK_EN: a write to DEPTH_WORDS*4+0x10 hits word 4; enables 0101 give valid with err=1 and no write.
- without QU_DMEM_ALIGN_CHECK_EN: err stays 0 for the same stimulus.
